// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO and sends each word as one frame (start, LSB-first data, stop).
// Optional even-parity bit after the data bits when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned CNT_W  = $clog2(DWIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  LAST_DATA   = CNT_W'(DWIDTH - 1);
  localparam logic [CNT_W-1:0]  LAST_STOP   = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef FIFO_UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   shreg_q, shreg_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                tx_q, tx_d;
  logic                bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                par_q;
`endif

  assign bit_end = (baud_q == '0);
  assign tx      = tx_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers; tx is registered from the next-state view so it switches with the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity captured from the popped word, independent of later FIFO head changes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       par_q <= 1'b0;
    else if (fifo_pop) par_q <= ^fifo_data;
  end
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    if (state_q != IDLE) begin
      baud_d = bit_end ? BAUD_RELOAD : baud_q - BAUD_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_d = START;
          shreg_d = fifo_data;
          baud_d  = BAUD_RELOAD;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d   = '0;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pop strobe and busy decode, plus the next line level
  always_comb begin
    fifo_pop = rst_ni && (state_q == IDLE) && enable && !fifo_empty;
    busy     = (state_q != IDLE);
    tx_d     = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmitter on the read side of the core's show-ahead FIFO: pops words from a FIFO, serialises them as asynchronous UART frames on a single line.
- Sits between the FIFO's pop/out/empty outputs and the board TX pin.
- Complements the FIFO's write side, which the CPU or bus fills.

Parameters:
- DWIDTH, 8, data bits per frame; also the FIFO word width consumed.
- BAUD_DIV, 434, clocks per bit period (50 MHz / 115200); legal range is 2 to 65535.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk_i  input  1  system clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- enable  input  1  when high, new frames may start; when low, no new FIFO pop.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DWIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_pop  output  1  single-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (START through last STOP).

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, tx=1, busy=0, fifo_pop=0.
  - Shift register, baud counter and bit counter are cleared.
  - Takes effect immediately mid-frame; the partial frame is abandoned and tx goes high at once.
- States: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE:
  - tx=1, busy=0.
  - fifo_pop is combinational and equals (state==IDLE && enable && !fifo_empty).
  - On the clock edge where fifo_pop=1: load shift register from fifo_data, load baud counter with BAUD_DIV-1, go to START.
  - fifo_pop is never high while fifo_empty=1. It is high for exactly one cycle per frame.
- Baud counter:
  - 16-bit down-counter.
  - A bit period ends on the cycle it reads 0; it then reloads BAUD_DIV-1.
  - Each line bit lasts exactly BAUD_DIV clocks.
- START: tx=0 for one bit period, then go to DATA with bit counter=0.
- DATA:
  - tx = shift register bit 0 (LSB first).
  - At each bit period end, shift right and increment bit counter.
  - After bit DWIDTH-1, go to STOP with stop counter=0.
- STOP:
  - tx=1 for STOP_BITS bit periods, then go to IDLE.
- tx timing:
  - tx is registered: it changes on the same edge as the state/bit transition.
  - No glitches.
- busy=1 in every state except IDLE.
- Frame length and spacing:
  - Frame length = BAUD_DIV*(1+DWIDTH+STOP_BITS) clocks from the first START cycle.
  - Back-to-back frames have exactly 1 clock of IDLE between the last stop cycle and the next START.
- enable deasserted mid-frame: the current frame completes normally; no pop until enable=1 again.
- FIFO becomes empty mid-frame: no effect on the current frame. The shift register holds a private copy, so fifo_data may change after the pop edge.
- Pop and FIFO push in the same cycle are legal; this block does not observe full.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the DWIDTH data bits) for one bit period.
  - Frame length becomes BAUD_DIV*(2+DWIDTH+STOP_BITS).
  - Parity is computed from the loaded word at pop time and held in a register.
- Not defined:
  - No PARITY state and no parity register.
  - Frames are start + data + stop only.

Test Plan:
- Reset values: hold rst_ni=0 with fifo_empty=0 and enable=1 -> tx=1, busy=0, fifo_pop=0. Release reset -> fifo_pop=1 on the first cycle.
- Single frame: BAUD_DIV=4, DWIDTH=8, STOP_BITS=1, fifo_data=0xA5 -> one-cycle fifo_pop, then tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks); busy=1 for those 40 clocks.
- Back-to-back: FIFO holds 0x00 then 0xFF, BAUD_DIV=4 -> second START begins exactly 1 clock after the first frame's stop ends; exactly two pops; fifo_pop never high while fifo_empty=1.
- Enable gating: drop enable 10 clocks into a frame of 0x3C -> frame completes intact, no further pop; raise enable -> next pop on the following cycle.
- Reset mid-frame: assert rst_ni=0 during DATA bit 3 -> tx=1 and busy=0 asynchronously. After release with fifo_empty=1 -> tx stays 1 and there are no pops.
- With FIFO_UART_TX_PARITY_EN, STOP_BITS=2, data 0x07 -> parity bit 1 after bit 7, then two stop periods; frame is 48 clocks at BAUD_DIV=4.
